// File: rtl/led_pkg.sv
// Shared types and default sizes for the LED fader.
// No logic; compile first.
// No backpressure.
package led_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } chan_state_t;

    localparam int LED_PWM_BITS = 8;
    localparam int LED_N        = 6;

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel: LOW/RISE/HIGH/FALL ramp FSM, brightness register, PWM compare.
// led is registered, one cycle behind bright/pwm_cnt; ramps advance only on step_tick.
// No backpressure; target is held stable by the parent while ramping.
module led_fader_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = LED_PWM_BITS,
    parameter int STEP     = 8
) (
    input  logic                clk50,
    input  logic                rst,
    input  logic                step_tick,
    input  logic                target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                ramping
);

    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(STEP);

    chan_state_t         state;
    logic [PWM_BITS-1:0] bright;

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state   <= LOW;
            bright  <= '0;
            led     <= 1'b0;
            ramping <= 1'b0;
        end else begin
            led <= (bright == MAX) || (bright > pwm_cnt);
            case (state)
                LOW: begin
                    if (target) begin
                        state   <= RISE;
                        ramping <= 1'b1;
                    end
                end
                // A step that lands on or past full scale ends the ramp in the same update.
                RISE: begin
                    if (step_tick) begin
                        if (bright >= MAX - STEP_V) begin
                            bright  <= MAX;
                            state   <= HIGH;
                            ramping <= 1'b0;
                        end else begin
                            bright <= bright + STEP_V;
                        end
                    end
                end
                HIGH: begin
                    if (!target) begin
                        state   <= FALL;
                        ramping <= 1'b1;
                    end
                end
                FALL: begin
                    if (step_tick) begin
                        if (bright <= STEP_V) begin
                            bright  <= '0;
                            state   <= LOW;
                            ramping <= 1'b0;
                        end else begin
                            bright <= bright - STEP_V;
                        end
                    end
                end
                default: begin
                    state   <= LOW;
                    ramping <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/led_fader.sv
// Fades N_LEDS board LEDs toward a requested on/off pattern with per-LED PWM.
// leds lag brightness by one cycle; each ramp takes ceil(MAX/STEP) step_ticks.
// pattern_ready drops for the cycle after an accept and while any channel ramps; no queuing.
module led_fader
    import led_pkg::*;
#(
    parameter int N_LEDS   = LED_N,
    parameter int PWM_BITS = LED_PWM_BITS,
    parameter int PWM_DIV  = 4,
    parameter int STEP     = 8
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              step_tick,
    input  logic [N_LEDS-1:0] pattern,
    input  logic              pattern_valid,
    output logic              pattern_ready,
    output logic              busy,
    output logic [N_LEDS-1:0] leds
);

    localparam int PS_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [N_LEDS-1:0]   target;
    logic [N_LEDS-1:0]   ramping;
    logic                pending;
    logic                accept;
    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;

    // ramping bits are flops updated with each channel's state, so busy tracks RISE/FALL exactly.
    assign busy          = |ramping;
    assign pattern_ready = !busy && !pending;
    assign accept        = pattern_valid && pattern_ready;

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            target  <= '0;
            pending <= 1'b0;
        end else begin
            pending <= accept;
            if (accept) begin
                target <= pattern;
            end
        end
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (prescaler == PS_W'(PWM_DIV - 1)) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fader_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk50     (clk50),
            .rst       (rst),
            .step_tick (step_tick),
            .target    (target[i]),
            .pwm_cnt   (pwm_cnt),
            .led       (leds[i]),
            .ramping   (ramping[i])
        );
    end

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader: stimulus queues expected observations tagged
// with the cycle they are due; a negedge monitor pops and compares them.
module tb_led_fader;

    logic       clk50 = 1'b0;
    logic       rst;
    logic       step_tick;
    logic [5:0] pattern;
    logic       pattern_valid;
    logic       pattern_ready;
    logic       busy;
    logic [5:0] leds;

    led_fader dut (
        .clk50         (clk50),
        .rst           (rst),
        .step_tick     (step_tick),
        .pattern       (pattern),
        .pattern_valid (pattern_valid),
        .pattern_ready (pattern_ready),
        .busy          (busy),
        .leds          (leds)
    );

    always #10 clk50 = ~clk50;

    int cnt = 0;
    always @(posedge clk50) cnt <= cnt + 1;

    typedef struct {
        string name;
        int    what;
        int    exp;
        int    cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   duty_cnt = 0;

    // Observation selectors: 0 bright ch0, 1 busy, 2 ready, 3 leds[0],
    // 4 target vector, 5 measured duty, 6 bright ch2, 7 leds other than ch2, 8 leds.
    function automatic int act(int what);
        case (what)
            0:       return int'(dut.g_ch[0].u_ch.bright);
            1:       return int'(busy);
            2:       return int'(pattern_ready);
            3:       return int'(leds[0]);
            4:       return int'(dut.target);
            5:       return duty_cnt;
            6:       return int'(dut.g_ch[2].u_ch.bright);
            7:       return int'(leds & 6'b111011);
            8:       return int'(leds);
            default: return -1;
        endcase
    endfunction

    task automatic compare(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cnt);
        end
    endtask

    task automatic push(input string name, input int what, input int exp, input int dly);
        exp_t x;
        x.name = name;
        x.what = what;
        x.exp  = exp;
        x.cyc  = cnt + dly;
        q.push_back(x);
    endtask

    always @(negedge clk50) begin
        while (q.size() > 0 && q[0].cyc <= cnt) begin
            e = q.pop_front();
            compare(e.name, act(e.what), e.exp);
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    task automatic tick();
        step_tick = 1'b1;
        cyc_n(1);
        step_tick = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        step_tick     = 1'b0;
        pattern_valid = 1'b0;
        pattern       = '0;
        #5;
        compare("init_leds", int'(leds), 0);
        compare("init_busy", int'(busy), 0);
        compare("init_ready", int'(pattern_ready), 1);
        cyc_n(3);
        rst = 1'b0;
        cyc_n(2);
        push("idle_ready", 2, 1, 0);
        push("idle_busy", 1, 0, 0);

        // Rise on channel 0; a new pattern is then held valid throughout the ramp.
        pattern       = 6'b000001;
        pattern_valid = 1'b1;
        push("pre_acc_ready", 2, 1, 0);
        cyc_n(1);
        pattern = 6'b000000;
        push("acc_ready", 2, 0, 0);
        push("acc_busy", 1, 0, 0);
        push("acc_target", 4, 1, 0);
        push("rise_busy_start", 1, 1, 1);
        push("rise_ready_low", 2, 0, 1);
        for (int t = 1; t <= 32; t++) begin
            cyc_n(19);
            tick();
            push("rise_bright", 0, (t * 8 > 255) ? 255 : t * 8, 0);
            push("rise_busy", 1, (t < 32) ? 1 : 0, 0);
            if (t == 16) push("held_target", 4, 1, 0);
        end
        push("high_ready", 2, 1, 0);
        push("high_target", 4, 1, 0);
        cyc_n(1);
        pattern_valid = 1'b0;
        push("held_acc_target", 4, 0, 0);
        push("held_acc_ready", 2, 0, 0);
        for (int k = 0; k < 4; k++) push("high_led", 3, 1, k * 5);

        // Fall on channel 0.
        for (int t = 1; t <= 32; t++) begin
            cyc_n(19);
            tick();
            push("fall_bright", 0, (255 - t * 8 < 0) ? 0 : 255 - t * 8, 0);
            push("fall_busy", 1, (t < 32) ? 1 : 0, 0);
        end
        for (int k = 0; k < 5; k++) push("low_led", 3, 0, 2 + k * 50);
        cyc_n(260);

        // Pattern equal to current levels: no ramp.
        pattern       = 6'b000000;
        pattern_valid = 1'b1;
        cyc_n(1);
        pattern_valid = 1'b0;
        push("eq_ready_pending", 2, 0, 0);
        cyc_n(1);
        push("eq_busy", 1, 0, 0);
        push("eq_ready", 2, 1, 0);
        push("eq_busy_later", 1, 0, 5);
        cyc_n(6);

        // Accept and step_tick together, then ramp channel 2.
        pattern       = 6'b000100;
        pattern_valid = 1'b1;
        step_tick     = 1'b1;
        cyc_n(1);
        pattern_valid = 1'b0;
        push("sim_bright_acc", 6, 0, 0);
        cyc_n(1);
        push("sim_bright_enter", 6, 0, 0);
        push("sim_busy", 1, 1, 0);
        cyc_n(1);
        step_tick = 1'b0;
        push("sim_first_step", 6, 8, 0);

        // Stop mid-ramp at 64 and measure one PWM period.
        repeat (7) begin
            cyc_n(3);
            tick();
        end
        push("duty_bright", 6, 64, 0);
        cyc_n(4);
        duty_cnt = 0;
        repeat (1024) begin
            cyc_n(1);
            if (leds[2]) duty_cnt++;
        end
        push("duty_high", 5, 256, 0);
        push("duty_others", 7, 0, 0);
        cyc_n(2);

        // Asynchronous reset mid-ramp with random inputs.
        compare("pre_rst_busy", int'(busy), 1);
        pattern       = 6'($urandom);
        pattern_valid = 1'($urandom);
        step_tick     = 1'($urandom);
        #3;
        rst = 1'b1;
        #1;
        compare("rst_leds", int'(leds), 0);
        compare("rst_busy", int'(busy), 0);
        compare("rst_ready", int'(pattern_ready), 1);
        compare("rst_bright2", int'(dut.g_ch[2].u_ch.bright), 0);
        cyc_n(2);
        pattern       = '0;
        pattern_valid = 1'b0;
        step_tick     = 1'b0;
        rst           = 1'b0;
        cyc_n(3);
        push("post_rst_busy", 1, 0, 0);
        push("post_rst_bright2", 6, 0, 0);
        cyc_n(5);
        tick();
        push("post_rst_tick_bright2", 6, 0, 0);
        push("post_rst_leds", 8, 0, 2);
        cyc_n(10);

        compare("queue_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
